// File: rtl/reg_fetch_ctrl.sv
// Operand fetch stage with a per-register pending scoreboard, writeback
// forwarding and a single output register stage under a valid/ready handshake.
module reg_fetch_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              iss_wb,
    output logic [ADDR_W-1:0] rf_rd_addr1,
    output logic [ADDR_W-1:0] rf_rd_addr2,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr_en,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rd,
    output logic              op_wb,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic              fwd1;
    logic              fwd2;
    logic              rd_cleared;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] opnd_a_p0;
    logic [DATA_W-1:0] opnd_b_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] op_a_p1;
    logic [DATA_W-1:0] op_b_p1;
    logic [ADDR_W-1:0] op_rd_p1;
    logic              op_wb_p1;

    assign rf_rd_addr1 = iss_rs1;
    assign rf_rd_addr2 = iss_rs2;
    assign rf_wr_en    = wb_valid;
    assign rf_wr_addr  = wb_addr;
    assign rf_wr_data  = wb_data;

    // Stage p0: forwarding, hazard detection and scoreboard update
    always_comb begin
        fwd1       = wb_valid && (wb_addr == iss_rs1);
        fwd2       = wb_valid && (wb_addr == iss_rs2);
        rd_cleared = wb_valid && (wb_addr == iss_rd);
        opnd_a_p0  = fwd1 ? wb_data : rf_rd_data1;
        opnd_b_p0  = fwd2 ? wb_data : rf_rd_data2;
        // A register being written back this cycle is no longer a hazard.
        hazard     = (pending[iss_rs1] && !fwd1) ||
                     (pending[iss_rs2] && !fwd2) ||
                     (iss_wb && pending[iss_rd] && !rd_cleared);
        iss_ready  = !hazard && (!vld_p1 || op_ready);
        accept     = iss_valid && iss_ready;
        // Clear first so a same-cycle set of the same register wins.
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (accept && iss_wb) begin
            pending_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Stage p1: operand output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            op_a_p1  <= '0;
            op_b_p1  <= '0;
            op_rd_p1 <= '0;
            op_wb_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            op_a_p1  <= opnd_a_p0;
            op_b_p1  <= opnd_b_p0;
            op_rd_p1 <= iss_rd;
            op_wb_p1 <= iss_wb;
        end else if (op_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign op_valid = vld_p1;
    assign op_a     = op_a_p1;
    assign op_b     = op_b_p1;
    assign op_rd    = op_rd_p1;
    assign op_wb    = op_wb_p1;

endmodule

// File: tb/tb_reg_fetch_ctrl.sv
// Scoreboard bench for reg_fetch_ctrl: a driver predicts each accepted operand
// from an array model of registers and pending bits; a monitor checks outputs.
module tb_reg_fetch_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          wb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iss_valid = 1'b0;
    logic          iss_ready;
    logic [AW-1:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic          iss_wb = 1'b0;
    logic [AW-1:0] rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
    logic [DW-1:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
    logic          rf_wr_en;
    logic          op_valid;
    logic          op_ready = 1'b0;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] op_rd;
    logic          op_wb;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;

    int checks = 0;
    int failures = 0;

    exp_t          q[$];
    logic [DW-1:0] mrf[4];
    logic          mp[4];
    logic          mov;
    logic [DW-1:0] rf[4];

    always #5 clk = ~clk;

    reg_fetch_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wb(iss_wb),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wb(op_wb),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    // Register file environment, written only through the DUT's write port.
    initial for (int i = 0; i < 4; i++) rf[i] = '0;
    always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: whatever the DUT presents must be the oldest predicted operand.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("op_valid", {31'd0, op_valid}, {31'd0, q.size() != 0});
            if (op_valid && q.size() != 0) begin
                chk("op_a", {24'd0, op_a}, {24'd0, q[0].a});
                chk("op_b", {24'd0, op_b}, {24'd0, q[0].b});
                chk("op_rd", {30'd0, op_rd}, {30'd0, q[0].rd});
                chk("op_wb", {31'd0, op_wb}, {31'd0, q[0].wb});
                if (op_ready) void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic cycle(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] rd, input logic w, input logic ordy,
                         input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic          busy1, busy2, busyd, er;
        logic [DW-1:0] ea, eb;
        iss_valid = v; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rd; iss_wb = w;
        op_ready = ordy; wb_valid = wv; wb_addr = wa; wb_data = wd;
        #1;
        ea    = (wv && wa == r1) ? wd : mrf[r1];
        eb    = (wv && wa == r2) ? wd : mrf[r2];
        busy1 = mp[r1] && !(wv && wa == r1);
        busy2 = mp[r2] && !(wv && wa == r2);
        busyd = w && mp[rd] && !(wv && wa == rd);
        er    = !(busy1 || busy2 || busyd) && (!mov || ordy);
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, er});
        chk("rf_rd_addr", {28'd0, rf_rd_addr1, rf_rd_addr2}, {28'd0, r1, r2});
        chk("rf_wr", {19'd0, rf_wr_en, rf_wr_addr, rf_wr_data}, {19'd0, wv, wa, wd});
        @(posedge clk);
        if (wv) mrf[wa] = wd;
        if (rst_n) begin
            if (wv) mp[wa] = 1'b0;
            if (v && er) begin
                if (w) mp[rd] = 1'b1;
                q.push_back('{a: ea, b: eb, rd: rd, wb: w});
                mov = 1'b1;
            end else if (ordy) begin
                mov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, '0, 1'b0, ordy, 1'b0, '0, '0);
    endtask

    // Asserts reset mid-cycle and checks that outputs drop without a clock edge.
    task automatic do_reset();
        iss_valid = 1'b0; wb_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        mov = 1'b0;
        for (int i = 0; i < 4; i++) mp[i] = 1'b0;
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_op_fields", {10'd0, op_a, op_b, op_rd, op_wb}, 32'd0);
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_op_valid_held", {31'd0, op_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mov = 1'b0;
        for (int i = 0; i < 4; i++) begin mrf[i] = '0; mp[i] = 1'b0; end
        @(posedge clk);
        #1;
        do_reset();

        // Preload r0..r3
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 8'h11);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1, 8'h22);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 2, 8'h33);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 3, 8'h44);

        // Basic fetch of r0, r1
        cycle(1'b1, 0, 1, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(1'b1);

        // RAW stall on r2, released by forwarded writeback
        cycle(1'b1, 0, 0, 2, 1'b1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 2, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 2, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 2, 0, 0, 1'b0, 1'b1, 1'b1, 2, 8'h5A);
        idle(1'b1);

        // Output backpressure for three cycles, then transfer with a new accept
        cycle(1'b1, 1, 3, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 2, 1, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 0, 2, 1, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(1'b1);

        // Same-cycle clear and set of r3: set wins
        cycle(1'b1, 0, 0, 3, 1'b1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1, 1, 3, 1'b1, 1'b1, 1'b1, 3, 8'h77);
        cycle(1'b1, 3, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 3, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 3, 3, 0, 1'b0, 1'b1, 1'b1, 3, 8'h99);
        idle(1'b1);

        // Back-to-back issues at full throughput
        for (int i = 0; i < 6; i++)
            cycle(1'b1, AW'(i), AW'(i + 1), AW'(i + 2), 1'b0, 1'b1, 1'b0, 0, 0);
        idle(1'b1);

        // Reset with a held operand and r1 pending
        cycle(1'b1, 0, 2, 1, 1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_reset();
        cycle(1'b1, 1, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1, 8'hC3);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 3) != 0), AW'($urandom), AW'($urandom), AW'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), AW'($urandom), DW'($urandom));

        for (int i = 0; i < 4; i++) idle(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
